// File: rtl/iram_loadable_mem_if.sv
`default_nettype none
// ============================================================================
// iram_loadable_mem_if : fetch port and byte-stream load bus for iram_loadable_mem
// IRAM_PARITY_EN adds PERR/PINJ.                                       Rev 1.0
// ============================================================================
interface iram_loadable_mem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] Q;
  logic              BUSY;
  logic              LD_START;
  logic              LD_VALID;
  logic [7:0]        LD_DATA;
  logic              LD_LAST;
  logic              LD_READY;
  logic              LD_DONE;
  logic              LD_ERR;
  logic [ADDR_W:0]   LD_WORDS;
`ifdef IRAM_PARITY_EN
  logic              PERR;
  logic              PINJ;

  modport master (
    output ADDR, LD_START, LD_VALID, LD_DATA, LD_LAST, PINJ,
    input  Q, BUSY, LD_READY, LD_DONE, LD_ERR, LD_WORDS, PERR
  );
  modport slave (
    input  ADDR, LD_START, LD_VALID, LD_DATA, LD_LAST, PINJ,
    output Q, BUSY, LD_READY, LD_DONE, LD_ERR, LD_WORDS, PERR
  );
`else
  modport master (
    output ADDR, LD_START, LD_VALID, LD_DATA, LD_LAST,
    input  Q, BUSY, LD_READY, LD_DONE, LD_ERR, LD_WORDS
  );
  modport slave (
    input  ADDR, LD_START, LD_VALID, LD_DATA, LD_LAST,
    output Q, BUSY, LD_READY, LD_DONE, LD_ERR, LD_WORDS
  );
`endif
endinterface
`default_nettype wire

// File: rtl/iram_loadable_mem.sv
`default_nettype none
// ============================================================================
// iram_loadable_mem : run-time loadable instruction RAM, cleared after reset,
// optional per-word even parity via IRAM_PARITY_EN.                    Rev 1.0
// ============================================================================
module iram_loadable_mem #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 128
) (
  input  wire logic          CLK,
  input  wire logic          RESET,
  iram_loadable_mem_if.slave bus
);
  localparam int BPW    = DATA_W / 8;
  localparam int OFF_W  = $clog2(BPW);
  localparam int BC_W   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W  = ADDR_W + 1;

  localparam logic [PTR_W-1:0] C_DEPTH     = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] C_DEPTH_M1  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] C_PTR_ONE   = PTR_W'(1);
  localparam logic [BC_W-1:0]  C_LAST_BYTE = BC_W'(BPW - 1);
  localparam logic [BC_W-1:0]  C_BC_ONE    = BC_W'(1);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t            state_q, state_d;
  // One pointer walks the array for both the clear sweep and the load
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [BC_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [PTR_W-1:0]  words_q, words_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              w_we;
  logic [MEM_AW-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_shifted;
  logic              w_room;
  logic [PTR_W-1:0]  w_ptr_inc;
  logic              w_busy;
  logic [ADDR_W-1:0] w_idx;
  logic              w_in_range;
  logic [MEM_AW-1:0] w_ridx;

  assign w_shifted = (asm_q << 8) | DATA_W'(bus.LD_DATA);
  assign w_room    = (ptr_q < C_DEPTH);
  assign w_ptr_inc = ptr_q + C_PTR_ONE;
  assign w_waddr   = MEM_AW'(ptr_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    done_d  = done_q;
    err_d   = err_q;
    words_d = words_q;
    w_we    = 1'b0;
    w_wdata = '0;

    case (state_q)
      ST_CLEAR: begin
        w_we  = 1'b1;
        ptr_d = w_ptr_inc;
        if (ptr_q == C_DEPTH_M1) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (bus.LD_START) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
          asm_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          words_d = '0;
        end
      end

      ST_LOAD: begin
        if (bus.LD_VALID) begin
          if (cnt_q == C_LAST_BYTE) begin
            cnt_d = '0;
            asm_d = '0;
            // Once full, words are dropped but bytes keep draining to LD_LAST
            if (w_room) begin
              w_we    = 1'b1;
              w_wdata = w_shifted;
              ptr_d   = w_ptr_inc;
            end else begin
              err_d = 1'b1;
            end
            if (bus.LD_LAST) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              words_d = w_room ? w_ptr_inc : ptr_q;
            end
          end else begin
            asm_d = w_shifted;
            cnt_d = cnt_q + C_BC_ONE;
            if (bus.LD_LAST) begin
              state_d = ST_FLUSH;
            end
          end
        end
      end

      ST_FLUSH: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        asm_d   = '0;
        done_d  = 1'b1;
        if (w_room) begin
          w_we    = 1'b1;
          w_wdata = asm_q << (8 * (BPW - int'(cnt_q)));
          ptr_d   = w_ptr_inc;
          words_d = w_ptr_inc;
        end else begin
          err_d   = 1'b1;
          words_d = ptr_q;
        end
      end

      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      done_q  <= done_d;
      err_q   <= err_d;
      words_q <= words_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_we && !RESET) begin
      mem[w_waddr] <= w_wdata;
    end
  end

  assign w_busy     = (state_q != ST_IDLE);
  assign w_idx      = bus.ADDR >> OFF_W;
  assign w_in_range = ({1'b0, w_idx} < C_DEPTH);
  assign w_ridx     = MEM_AW'(w_idx);

  assign bus.Q        = (!w_busy && w_in_range) ? mem[w_ridx] : '0;
  assign bus.BUSY     = w_busy;
  assign bus.LD_READY = (state_q == ST_LOAD);
  assign bus.LD_DONE  = done_q;
  assign bus.LD_ERR   = err_q;
  assign bus.LD_WORDS = words_q;

`ifdef IRAM_PARITY_EN
  logic mem_par [DEPTH];
  logic w_wpar;

  // Clear sweep stores parity 0, matching the all-zero data it writes
  assign w_wpar = (state_q == ST_CLEAR) ? 1'b0 : ((^w_wdata) ^ bus.PINJ);

  always_ff @(posedge CLK) begin
    if (w_we && !RESET) begin
      mem_par[w_waddr] <= w_wpar;
    end
  end

  assign bus.PERR = !w_busy && w_in_range && (mem_par[w_ridx] != (^mem[w_ridx]));
`endif

endmodule
`default_nettype wire

// File: tb/tb_iram_loadable_mem.sv
`default_nettype none
// ============================================================================
// tb_iram_loadable_mem : scoreboard bench for iram_loadable_mem
// Rev 1.0
// ============================================================================
module tb_iram_loadable_mem;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iram_loadable_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  iram_loadable_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] model [DEPTH];
  logic [15:0] sb_q [$];
  logic [7:0]  stream [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset_and_clear(input bit poke_start);
    int busy_cycles = 0;
    rst = 1'b1;
    bus.LD_START = 1'b0;
    bus.LD_VALID = 1'b0;
    bus.LD_LAST  = 1'b0;
    bus.ADDR     = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy",  bus.BUSY, 1);
    check("rst_done",  bus.LD_DONE, 0);
    check("rst_err",   bus.LD_ERR, 0);
    check("rst_words", bus.LD_WORDS, 0);
    check("rst_ready", bus.LD_READY, 0);
    check("rst_q",     bus.Q, 0);
    while (bus.BUSY === 1'b1 && busy_cycles < 400) begin
      busy_cycles++;
      bus.LD_START = poke_start && (busy_cycles == 10);
      @(negedge clk);
    end
    bus.LD_START = 1'b0;
    check("clear_cycles", busy_cycles, DEPTH);
    check("clear_ready",  bus.LD_READY, 0);
    for (int w = 0; w < DEPTH; w++) model[w] = 16'h0000;
  endtask

  task automatic load_stream(input string tag, input bit gaps, input bit poke_start);
    int n = stream.size();
    int nw;
    int timeout;
    int stalls = 0;
    @(posedge clk); #1;
    bus.LD_START = 1'b1;
    @(posedge clk); #1;
    bus.LD_START = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        bus.LD_VALID = 1'b0;
        bus.LD_START = poke_start && (i == 1);
        @(posedge clk); #1;
        bus.LD_START = 1'b0;
      end
      bus.LD_VALID = 1'b1;
      bus.LD_DATA  = stream[i];
      bus.LD_LAST  = (i == n - 1);
      timeout = 0;
      @(negedge clk);
      while (bus.LD_READY !== 1'b1 && timeout < 50) begin
        timeout++;
        @(negedge clk);
      end
      if (timeout >= 50) stalls++;
      @(posedge clk); #1;
    end
    bus.LD_VALID = 1'b0;
    bus.LD_LAST  = 1'b0;
    check({tag, "_ready"}, stalls, 0);

    nw = (n + 1) / 2;
    for (int w = 0; w < nw && w < DEPTH; w++)
      model[w] = {stream[2*w], (2*w + 1 < n) ? stream[2*w + 1] : 8'h00};

    timeout = 0;
    @(negedge clk);
    while (bus.BUSY !== 1'b0 && timeout < 50) begin
      timeout++;
      @(negedge clk);
    end
    check({tag, "_finish"}, (timeout < 50), 1);
    check({tag, "_done"},  bus.LD_DONE, 1);
    check({tag, "_err"},   bus.LD_ERR, (nw > DEPTH));
    check({tag, "_words"}, bus.LD_WORDS, (nw > DEPTH) ? DEPTH : nw);
  endtask

  task automatic read_word(input logic [7:0] addr);
    logic [15:0] exp;
    bus.ADDR = addr;
    sb_q.push_back(model[addr >> 1]);
    @(negedge clk);
    exp = sb_q.pop_front();
    check($sformatf("q_at_%02h", addr), bus.Q, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.ADDR     = 8'h00;
    bus.LD_START = 1'b0;
    bus.LD_VALID = 1'b0;
    bus.LD_DATA  = 8'h00;
    bus.LD_LAST  = 1'b0;
`ifdef IRAM_PARITY_EN
    bus.PINJ     = 1'b0;
`endif
    repeat (2) @(posedge clk);

    do_reset_and_clear(1'b0);
    read_word(8'h00);
    read_word(8'hFE);

    stream = '{8'hF0, 8'h01, 8'hF2, 8'h91};
    load_stream("t2", 1'b0, 1'b0);
    read_word(8'h00);
    read_word(8'h03);
    check("t2_lit_w1", bus.Q, 16'hF291);

    stream = '{8'hF0, 8'h01, 8'hF2, 8'h91, 8'h5F};
    load_stream("t3", 1'b1, 1'b1);
    read_word(8'h00);
    read_word(8'h02);
    read_word(8'h04);
    check("t3_lit_w2", bus.Q, 16'h5F00);
    read_word(8'h05);

    stream.delete();
    for (int i = 0; i < 260; i++) stream.push_back(8'((i * 7 + 3) & 8'hFF));
    load_stream("t4", 1'b0, 1'b0);
    read_word(8'h00);
    read_word(8'h02);
    read_word(8'h80);
    read_word(8'hFC);
    read_word(8'hFF);

    stream = '{8'h12, 8'h34};
    load_stream("t4b", 1'b0, 1'b0);
    read_word(8'h00);
    read_word(8'h02);

    @(posedge clk); #1;
    bus.LD_START = 1'b1;
    @(posedge clk); #1;
    bus.LD_START = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.LD_VALID = 1'b1;
      bus.LD_DATA  = 8'hA0 + 8'(i);
      bus.LD_LAST  = 1'b0;
      @(posedge clk); #1;
    end
    bus.LD_VALID = 1'b0;
    do_reset_and_clear(1'b1);
    check("t5_done", bus.LD_DONE, 0);
    for (int w = 0; w < DEPTH; w++) read_word(8'(w * 2));

`ifdef IRAM_PARITY_EN
    stream = '{8'h00, 8'h01};
    bus.PINJ = 1'b1;
    load_stream("p1", 1'b0, 1'b0);
    bus.PINJ = 1'b0;
    read_word(8'h00);
    check("p1_perr", bus.PERR, 1);
    load_stream("p2", 1'b0, 1'b0);
    read_word(8'h00);
    check("p2_perr", bus.PERR, 0);
`endif

    check("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
